// File: rtl/cond_flag_unit_if.sv
// Flag/condition interface between the decoder/ALU side (master) and
// the condition-flag unit (slave).
interface cond_flag_unit_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       NoWrite;
  logic       MemW;
  logic       MStart;
  logic       MCycleDone;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       MCycleStart;
  logic       Stall;
  logic       C_Flag;
  logic [3:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, NoWrite, MemW, MStart, MCycleDone,
    input  PCSrc, RegWrite, MemWrite, MCycleStart, Stall, C_Flag, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, NoWrite, MemW, MStart, MCycleDone,
    output PCSrc, RegWrite, MemWrite, MCycleStart, Stall, C_Flag, Flags
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register, ARM condition evaluation, write gating and
// multi-cycle (MUL/DIV) stall sequencing.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RST   = 4'b0000,
  parameter logic       COND_NV_EX = 1'b1
) (
  input  logic           CLK,
  input  logic           RESET,
  cond_flag_unit_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_r;
  logic [3:0] flags_r;
  logic       pend_nz_r;
  logic       cond_ex_s;
  logic       pc_src_s;
  logic       reg_write_s;
  logic       mem_write_s;
  logic       mcycle_start_s;
  logic       stall_s;

  // ARM condition table over the registered {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c & !z;
      4'b1001: res = !c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      4'b1111: res = COND_NV_EX;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign cond_ex_s = cond_eval(bus.Cond, flags_r);

  // Gated write enables, start pulse and stall for the current cycle
  always_comb begin
    pc_src_s       = 1'b0;
    reg_write_s    = 1'b0;
    mem_write_s    = 1'b0;
    mcycle_start_s = 1'b0;
    stall_s        = 1'b0;
    if (RESET) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.MStart) begin
            pc_src_s    = bus.PCS & cond_ex_s;
            reg_write_s = bus.RegW & cond_ex_s & !bus.NoWrite;
            mem_write_s = bus.MemW & cond_ex_s;
          end else if (cond_ex_s) begin
            mcycle_start_s = 1'b1;
            stall_s        = 1'b1;
          end else begin
            stall_s = 1'b0;
          end
        end
        BUSY: begin
          if (bus.MCycleDone) begin
            reg_write_s = 1'b1;
          end else begin
            stall_s = 1'b1;
          end
        end
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Flag register and IDLE/BUSY sequencing; a failed condition leaves both untouched
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= IDLE;
      flags_r   <= FLAG_RST;
      pend_nz_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.MStart) begin
            if (cond_ex_s) begin
              pend_nz_r <= bus.FlagW[1];
              state_r   <= BUSY;
            end
          end else if (cond_ex_s) begin
            if (bus.FlagW[1]) flags_r[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagW[0]) flags_r[1:0] <= bus.ALUFlags[1:0];
          end
        end
        BUSY: begin
          // Multi-cycle ops only ever update N and Z
          if (bus.MCycleDone) begin
            if (pend_nz_r) flags_r[3:2] <= bus.ALUFlags[3:2];
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.PCSrc       = pc_src_s;
  assign bus.RegWrite    = reg_write_s;
  assign bus.MemWrite    = mem_write_s;
  assign bus.MCycleStart = mcycle_start_s;
  assign bus.Stall       = stall_s;
  assign bus.C_Flag      = flags_r[1];
  assign bus.Flags       = flags_r;

endmodule
